// File: rtl/axi_ni_resp_scheduler.sv
// ---------------------------------------------------------------------------
// axi_ni_resp_scheduler
//
// Purpose:
//   Response scheduler for the AXI target NI resend path. It chooses which
//   AXI ID's buffered write or read response is packetised next. It then
//   drives the header/payload sample pulses and the send handshake, and pops
//   the per-ID response and source FIFOs once the packet has left.
//   Two arbitration policies are available:
//     ARB_MODE 0 : plain round-robin over IDs; write wins within an ID.
//     ARB_MODE 1 : reads first, with a starvation guard that forces a
//                  write grant after STARVE_LIMIT reads have bypassed one.
//   A multi-beat read burst stays locked to its ID until RLAST is popped.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   br_rempty / rr_rempty    per-ID write-response / read-data FIFO empty
//   wrr_rempty / rdr_rempty  per-ID write-source / read-source FIFO empty
//   last_beat                RLAST of the read-data FIFO head for curr_tid
//   tx_gone                  transmit side finished the current packet
//   br_rinc .. rdr_rinc      one-hot FIFO pop pulses (RETIRE only)
//   curr_tid                 granted ID
//   packet_type_is_read      1 = read response, 0 = write response
//   sample_header            header register sample pulse
//   sample_payload           payload register sample pulse
//   send_message             held while the packet is in flight
//   num_flit_to_transmit     flit count of the current packet
//   busy                     scheduler is not idle
//   starved                  a forced write grant is pending (ARB_MODE 1)
// ---------------------------------------------------------------------------
module axi_ni_resp_scheduler #(
  parameter int MAX_SUPPORTED_IDS = 16,
  parameter int IDWD              = 4,
  parameter int FLITCNTWD         = 4,
  parameter int WR_FLITS          = 2,
  parameter int RD_FLITS          = 3,
  parameter int ARB_MODE          = 0,
  parameter int STARVE_LIMIT      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MAX_SUPPORTED_IDS-1:0] br_rempty,
  input  logic [MAX_SUPPORTED_IDS-1:0] rr_rempty,
  input  logic [MAX_SUPPORTED_IDS-1:0] wrr_rempty,
  input  logic [MAX_SUPPORTED_IDS-1:0] rdr_rempty,
  input  logic                         last_beat,
  input  logic                         tx_gone,
  output logic [MAX_SUPPORTED_IDS-1:0] br_rinc,
  output logic [MAX_SUPPORTED_IDS-1:0] rr_rinc,
  output logic [MAX_SUPPORTED_IDS-1:0] wrr_rinc,
  output logic [MAX_SUPPORTED_IDS-1:0] rdr_rinc,
  output logic [IDWD-1:0]              curr_tid,
  output logic                         packet_type_is_read,
  output logic                         sample_header,
  output logic                         sample_payload,
  output logic                         send_message,
  output logic [FLITCNTWD-1:0]         num_flit_to_transmit,
  output logic                         busy,
  output logic                         starved
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_SEND       = 3'd2;
  localparam logic [2:0] S_RETIRE     = 3'd3;
  localparam logic [2:0] S_BURST_WAIT = 3'd4;

  // Sized so the counter can hold STARVE_LIMIT itself (saturating value).
  localparam int             CNTWD = $clog2(STARVE_LIMIT + 2);
  localparam logic [CNTWD-1:0] LIMIT = CNTWD'(STARVE_LIMIT);

  logic [2:0]                   state;
  logic [IDWD-1:0]              rr_ptr;
  logic [CNTWD-1:0]             starve_cnt;
  logic [CNTWD-1:0]             starve_nxt;
  logic                         burst_last;

  logic [MAX_SUPPORTED_IDS-1:0] wr_rdy;
  logic [MAX_SUPPORTED_IDS-1:0] rd_rdy;
  logic [MAX_SUPPORTED_IDS-1:0] tid_onehot;
  logic                         wr_found;
  logic                         rd_found;
  logic                         any_found;
  logic [IDWD-1:0]              wr_id;
  logic [IDWD-1:0]              rd_id;
  logic [IDWD-1:0]              any_id;
  logic                         starve_hit;
  logic [IDWD-1:0]              grant_id;
  logic                         grant_read;
  logic [IDWD-1:0]              next_ptr;

  // An ID is only eligible when both the response data and its source
  // bookkeeping entry are present.
  assign wr_rdy = ~br_rempty & ~wrr_rempty;
  assign rd_rdy = ~rr_rempty & ~rdr_rempty;

  assign tid_onehot = {{(MAX_SUPPORTED_IDS-1){1'b0}}, 1'b1} << curr_tid;
  assign next_ptr   = (curr_tid == IDWD'(MAX_SUPPORTED_IDS - 1)) ? '0 : curr_tid + IDWD'(1);
  assign starve_hit = (ARB_MODE == 1) && (starve_cnt == LIMIT);

  // Three parallel priority searches starting at rr_ptr and wrapping, one
  // per candidate class; the policy below picks among their winners.
  always_comb begin
    int              idx;
    logic [IDWD-1:0] idx_l;
    wr_found  = 1'b0;
    rd_found  = 1'b0;
    any_found = 1'b0;
    wr_id     = '0;
    rd_id     = '0;
    any_id    = '0;
    idx       = 0;
    idx_l     = '0;
    for (int k = 0; k < MAX_SUPPORTED_IDS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= MAX_SUPPORTED_IDS) idx = idx - MAX_SUPPORTED_IDS;
      idx_l = IDWD'(idx);
      if (!wr_found && wr_rdy[idx_l]) begin
        wr_found = 1'b1;
        wr_id    = idx_l;
      end
      if (!rd_found && rd_rdy[idx_l]) begin
        rd_found = 1'b1;
        rd_id    = idx_l;
      end
      if (!any_found && (wr_rdy[idx_l] || rd_rdy[idx_l])) begin
        any_found = 1'b1;
        any_id    = idx_l;
      end
    end
  end

  // Grant policy. In read-priority mode a saturated starvation counter
  // overrides the read preference while a write is waiting.
  always_comb begin
    grant_id   = any_id;
    grant_read = !wr_rdy[any_id];
    if (ARB_MODE == 1) begin
      if (starve_hit && wr_found) begin
        grant_id   = wr_id;
        grant_read = 1'b0;
      end else if (rd_found) begin
        grant_id   = rd_id;
        grant_read = 1'b1;
      end else begin
        grant_id   = wr_id;
        grant_read = 1'b0;
      end
    end
  end

  // Starvation counter update applied at grant time: a read grant that
  // bypasses a ready write counts up (saturating), any write grant clears.
  always_comb begin
    starve_nxt = starve_cnt;
    if (!grant_read)
      starve_nxt = '0;
    else if (wr_found && (starve_cnt != LIMIT))
      starve_nxt = starve_cnt + CNTWD'(1);
  end

  // Main FSM. Every output is a register; pulse outputs default low each
  // cycle and are set on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      rr_ptr               <= '0;
      starve_cnt           <= '0;
      burst_last           <= 1'b0;
      br_rinc              <= '0;
      rr_rinc              <= '0;
      wrr_rinc             <= '0;
      rdr_rinc             <= '0;
      curr_tid             <= '0;
      packet_type_is_read  <= 1'b0;
      sample_header        <= 1'b0;
      sample_payload       <= 1'b0;
      send_message         <= 1'b0;
      num_flit_to_transmit <= '0;
      busy                 <= 1'b0;
      starved              <= 1'b0;
    end else begin
      sample_header  <= 1'b0;
      sample_payload <= 1'b0;
      br_rinc        <= '0;
      rr_rinc        <= '0;
      wrr_rinc       <= '0;
      rdr_rinc       <= '0;
      case (state)
        S_IDLE: begin
          if (any_found) begin
            curr_tid             <= grant_id;
            packet_type_is_read  <= grant_read;
            num_flit_to_transmit <= grant_read ? FLITCNTWD'(RD_FLITS) : FLITCNTWD'(WR_FLITS);
            sample_header        <= 1'b1;
            sample_payload       <= 1'b1;
            busy                 <= 1'b1;
            state                <= S_LOAD;
            if (ARB_MODE == 1) begin
              starve_cnt <= starve_nxt;
              starved    <= (starve_nxt == LIMIT);
            end
          end
        end
        S_LOAD: begin
          send_message <= 1'b1;
          state        <= S_SEND;
        end
        S_SEND: begin
          if (tx_gone) begin
            send_message <= 1'b0;
            state        <= S_RETIRE;
            // last_beat is still the FIFO head here, so it decides whether
            // the read-source entry is popped together with this beat.
            if (packet_type_is_read) begin
              rr_rinc    <= tid_onehot;
              rdr_rinc   <= last_beat ? tid_onehot : '0;
              burst_last <= last_beat;
            end else begin
              br_rinc    <= tid_onehot;
              wrr_rinc   <= tid_onehot;
              burst_last <= 1'b0;
            end
          end
        end
        S_RETIRE: begin
          if (!packet_type_is_read || burst_last) begin
            rr_ptr <= next_ptr;
            busy   <= 1'b0;
            state  <= S_IDLE;
          end else begin
            state <= S_BURST_WAIT;
          end
        end
        S_BURST_WAIT: begin
          // Burst stays locked to curr_tid; only the payload is re-sampled.
          if (!rr_rempty[curr_tid]) begin
            sample_payload <= 1'b1;
            state          <= S_LOAD;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ni_resp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_axi_ni_resp_scheduler
//
// Directed bench for axi_ni_resp_scheduler. Two instances share stimulus:
// dut0 uses round-robin arbitration, dut1 read-priority with STARVE_LIMIT=2.
// A small FIFO occupancy model drives the rempty inputs; expected packets
// are queued as stimulus is set up and popped as the DUT samples them.
// ---------------------------------------------------------------------------
module tb_axi_ni_resp_scheduler;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic tx_gone;
  logic last_beat;
  logic [N-1:0] br_rempty, rr_rempty, wrr_rempty, rdr_rempty;

  logic [N-1:0] br_rinc0, rr_rinc0, wrr_rinc0, rdr_rinc0;
  logic [N-1:0] br_rinc1, rr_rinc1, wrr_rinc1, rdr_rinc1;
  logic [3:0]   curr_tid0, curr_tid1;
  logic         is_rd0, is_rd1, shdr0, shdr1, spay0, spay1, send0, send1;
  logic [3:0]   nflit0, nflit1;
  logic         busy0, busy1, starved0, starved1;

  logic [N-1:0] br_rinc, rr_rinc, wrr_rinc, rdr_rinc;
  logic [3:0]   curr_tid;
  logic         packet_type_is_read, sample_header, sample_payload, send_message;
  logic [3:0]   num_flit_to_transmit;
  logic         busy, starved;

  int           wr_cnt[N];
  int           rd_cnt[N];
  logic [N-1:0] rd_hold;

  typedef struct packed {
    logic [3:0] tid;
    logic       rd;
    logic       hdr;
    logic       last;
    logic       stv;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  axi_ni_resp_scheduler #(.ARB_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .br_rempty(br_rempty), .rr_rempty(rr_rempty),
    .wrr_rempty(wrr_rempty), .rdr_rempty(rdr_rempty),
    .last_beat(last_beat), .tx_gone(tx_gone),
    .br_rinc(br_rinc0), .rr_rinc(rr_rinc0), .wrr_rinc(wrr_rinc0), .rdr_rinc(rdr_rinc0),
    .curr_tid(curr_tid0), .packet_type_is_read(is_rd0),
    .sample_header(shdr0), .sample_payload(spay0), .send_message(send0),
    .num_flit_to_transmit(nflit0), .busy(busy0), .starved(starved0)
  );

  axi_ni_resp_scheduler #(.ARB_MODE(1), .STARVE_LIMIT(2)) dut1 (
    .clk(clk), .rst(rst),
    .br_rempty(br_rempty), .rr_rempty(rr_rempty),
    .wrr_rempty(wrr_rempty), .rdr_rempty(rdr_rempty),
    .last_beat(last_beat), .tx_gone(tx_gone),
    .br_rinc(br_rinc1), .rr_rinc(rr_rinc1), .wrr_rinc(wrr_rinc1), .rdr_rinc(rdr_rinc1),
    .curr_tid(curr_tid1), .packet_type_is_read(is_rd1),
    .sample_header(shdr1), .sample_payload(spay1), .send_message(send1),
    .num_flit_to_transmit(nflit1), .busy(busy1), .starved(starved1)
  );

  // Route the instance under test onto the common observation signals.
  always_comb begin
    br_rinc              = sel ? br_rinc1  : br_rinc0;
    rr_rinc              = sel ? rr_rinc1  : rr_rinc0;
    wrr_rinc             = sel ? wrr_rinc1 : wrr_rinc0;
    rdr_rinc             = sel ? rdr_rinc1 : rdr_rinc0;
    curr_tid             = sel ? curr_tid1 : curr_tid0;
    packet_type_is_read  = sel ? is_rd1    : is_rd0;
    sample_header        = sel ? shdr1     : shdr0;
    sample_payload       = sel ? spay1     : spay0;
    send_message         = sel ? send1     : send0;
    num_flit_to_transmit = sel ? nflit1    : nflit0;
    busy                 = sel ? busy1     : busy0;
    starved              = sel ? starved1  : starved0;
  end

  // FIFO occupancy model: counts of queued write responses and remaining
  // read beats per ID; rd_hold delays the next read beat of a burst.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      br_rempty[i]  = (wr_cnt[i] == 0);
      wrr_rempty[i] = (wr_cnt[i] == 0);
      rr_rempty[i]  = (rd_cnt[i] == 0) || rd_hold[i];
      rdr_rempty[i] = (rd_cnt[i] == 0);
    end
    last_beat = (rd_cnt[curr_tid] == 1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int id, input int wr_n, input int rd_n);
    wr_cnt[id] = wr_cnt[id] + wr_n;
    rd_cnt[id] = rd_cnt[id] + rd_n;
  endtask

  task automatic expectPkt(input int tid, input logic rd, input logic hdr,
                           input logic last, input logic stv);
    exp_t e;
    e.tid  = 4'(tid);
    e.rd   = rd;
    e.hdr  = hdr;
    e.last = last;
    e.stv  = stv;
    sb.push_back(e);
  endtask

  // Waits for the next sample pulse, checks it against the scoreboard head,
  // walks the send handshake and the retire pops, then updates the FIFO
  // model. Optionally holds the next read beat back for 'hold' cycles.
  task automatic servePacket(input int hold, output int waited);
    exp_t         e;
    logic [N-1:0] oh;
    int           w;
    w = 0;
    while (sample_payload !== 1'b1 && w < 40) begin
      tick();
      w++;
      checkOutput("pops_outside_retire", 32'(br_rinc | rr_rinc | wrr_rinc | rdr_rinc), 32'd0);
    end
    waited = w;
    if (sample_payload !== 1'b1) begin
      vectors++;
      errors++;
      $display("[TB] FAIL grant_timeout: observed no sample_payload within 40 cycles, required a grant");
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      vectors++;
      errors++;
      $display("[TB] FAIL unexpected_grant: observed tid %0d, required no packet", curr_tid);
      return;
    end
    e  = sb.pop_front();
    oh = N'(1) << e.tid;
    checkOutput("curr_tid", 32'(curr_tid), 32'(e.tid));
    checkOutput("packet_type", 32'(packet_type_is_read), 32'(e.rd));
    checkOutput("sample_header", 32'(sample_header), 32'(e.hdr));
    checkOutput("num_flit", 32'(num_flit_to_transmit), e.rd ? 32'd3 : 32'd2);
    checkOutput("busy_load", 32'(busy), 32'd1);
    checkOutput("starved", 32'(starved), 32'(e.stv));
    tick();
    checkOutput("send_rise", 32'(send_message), 32'd1);
    checkOutput("payload_pulse_end", 32'(sample_payload), 32'd0);
    tick();
    checkOutput("send_hold", 32'(send_message), 32'd1);
    tx_gone = 1'b1;
    tick();
    tx_gone = 1'b0;
    checkOutput("send_drop", 32'(send_message), 32'd0);
    checkOutput("br_rinc", 32'(br_rinc), e.rd ? 32'd0 : 32'(oh));
    checkOutput("wrr_rinc", 32'(wrr_rinc), e.rd ? 32'd0 : 32'(oh));
    checkOutput("rr_rinc", 32'(rr_rinc), e.rd ? 32'(oh) : 32'd0);
    checkOutput("rdr_rinc", 32'(rdr_rinc), (e.rd && e.last) ? 32'(oh) : 32'd0);
    if (e.rd) begin
      if (rd_cnt[e.tid] > 0) rd_cnt[e.tid] = rd_cnt[e.tid] - 1;
    end else begin
      if (wr_cnt[e.tid] > 0) wr_cnt[e.tid] = wr_cnt[e.tid] - 1;
    end
    if (hold > 0) begin
      rd_hold[e.tid] = 1'b1;
      repeat (hold) begin
        tick();
        checkOutput("burst_wait_send", 32'(send_message), 32'd0);
        checkOutput("burst_wait_sample", 32'(sample_payload), 32'd0);
        checkOutput("burst_wait_busy", 32'(busy), 32'd1);
        checkOutput("burst_wait_tid", 32'(curr_tid), 32'(e.tid));
      end
      rd_hold[e.tid] = 1'b0;
    end
  endtask

  // Directed sequence: reset, round-robin order, wrap, locked read burst with
  // a stalled beat, reset mid-packet, then read priority and starvation.
  initial begin
    int w;
    sel     = 1'b0;
    rst     = 1'b1;
    tx_gone = 1'b0;
    rd_hold = '0;
    for (int i = 0; i < N; i++) begin
      wr_cnt[i] = 0;
      rd_cnt[i] = 0;
    end
    tick();
    tick();
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_send", 32'(send_message), 32'd0);
    checkOutput("reset_tid", 32'(curr_tid), 32'd0);
    checkOutput("reset_pops", 32'(br_rinc | rr_rinc | wrr_rinc | rdr_rinc), 32'd0);
    checkOutput("reset_samples", 32'({sample_header, sample_payload}), 32'd0);
    rst = 1'b0;

    $display("[TB] round-robin: writes on IDs 2 and 5");
    applyStimulus(2, 1, 0);
    applyStimulus(5, 1, 0);
    expectPkt(2, 1'b0, 1'b1, 1'b0, 1'b0);
    expectPkt(5, 1'b0, 1'b1, 1'b0, 1'b0);
    servePacket(0, w);
    checkOutput("grant_latency", 32'(w), 32'd1);
    servePacket(0, w);

    $display("[TB] pointer after ID 5: writes on IDs 4 and 7");
    applyStimulus(4, 1, 0);
    applyStimulus(7, 1, 0);
    expectPkt(7, 1'b0, 1'b1, 1'b0, 1'b0);
    expectPkt(4, 1'b0, 1'b1, 1'b0, 1'b0);
    servePacket(0, w);
    servePacket(0, w);

    $display("[TB] wrap: ID 14 then IDs 0 and 1");
    applyStimulus(14, 1, 0);
    expectPkt(14, 1'b0, 1'b1, 1'b0, 1'b0);
    servePacket(0, w);
    applyStimulus(1, 1, 0);
    applyStimulus(0, 1, 0);
    expectPkt(0, 1'b0, 1'b1, 1'b0, 1'b0);
    expectPkt(1, 1'b0, 1'b1, 1'b0, 1'b0);
    servePacket(0, w);
    servePacket(0, w);

    $display("[TB] read burst of 4 on ID 3 with write pending on ID 1");
    applyStimulus(2, 1, 0);
    expectPkt(2, 1'b0, 1'b1, 1'b0, 1'b0);
    servePacket(0, w);
    applyStimulus(3, 0, 4);
    applyStimulus(1, 1, 0);
    expectPkt(3, 1'b1, 1'b1, 1'b0, 1'b0);
    expectPkt(3, 1'b1, 1'b0, 1'b0, 1'b0);
    expectPkt(3, 1'b1, 1'b0, 1'b0, 1'b0);
    expectPkt(3, 1'b1, 1'b0, 1'b1, 1'b0);
    expectPkt(1, 1'b0, 1'b1, 1'b0, 1'b0);
    servePacket(5, w);
    servePacket(0, w);
    servePacket(0, w);
    servePacket(0, w);
    servePacket(0, w);

    $display("[TB] reset while sending on ID 6");
    applyStimulus(6, 1, 0);
    w = 0;
    while (sample_payload !== 1'b1 && w < 40) begin
      tick();
      w++;
    end
    checkOutput("abort_tid", 32'(curr_tid), 32'd6);
    tick();
    checkOutput("abort_send_before", 32'(send_message), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("abort_send", 32'(send_message), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_pops", 32'(br_rinc | rr_rinc | wrr_rinc | rdr_rinc), 32'd0);
    rst = 1'b0;
    expectPkt(6, 1'b0, 1'b1, 1'b0, 1'b0);
    servePacket(0, w);

    $display("[TB] read priority with starvation guard (limit 2)");
    sel = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("m1_reset_starved", 32'(starved), 32'd0);
    applyStimulus(0, 0, 1);
    applyStimulus(7, 1, 0);
    expectPkt(0, 1'b1, 1'b1, 1'b1, 1'b0);
    expectPkt(0, 1'b1, 1'b1, 1'b1, 1'b1);
    expectPkt(7, 1'b0, 1'b1, 1'b0, 1'b0);
    expectPkt(0, 1'b1, 1'b1, 1'b1, 1'b0);
    servePacket(0, w);
    applyStimulus(0, 0, 1);
    servePacket(0, w);
    applyStimulus(0, 0, 1);
    servePacket(0, w);
    servePacket(0, w);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
